// File: rtl/kij_pass_sequencer.sv
// kij_pass_sequencer: emits the 34-bit core instruction word that sequences one kij pass.
// The pass runs in this order:
//   1. weight xmem->L0
//   2. L0->PE load
//   3. gap
//   4. activation xmem->L0
//   5. execute
//   6. OFIFO->pmem drain
// Optional feature macro: SEQ_TIMEOUT_EN enables the DRAIN watchdog. Without it, err stays 0.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low
//   start        begin a pass; sampled only in IDLE
//   w_base       xmem base address for weights; latched on start
//   a_base       xmem base address for activations; latched on start
//   p_base       pmem base address for psums; latched on start
//   ofifo_valid  OFIFO holds a readable row
//   inst         registered instruction word to core.inst
//   busy         registered; high in every state except IDLE
//   done         registered one-cycle pulse at the end of a pass
//   err          registered, sticky watchdog flag; cleared by the next start
module kij_pass_sequencer #(
    parameter int unsigned ROW     = 8,
    parameter int unsigned LEN_NIJ = 36,
    parameter int unsigned GAP     = 10,
    parameter int unsigned ADDR_W  = 11
`ifdef SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 64
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic              ofifo_valid,
    output logic [33:0]       inst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned INST_W  = 34;
    localparam int unsigned MAX_AB  = (LEN_NIJ > ROW) ? LEN_NIJ : ROW;
    localparam int unsigned CNT_MAX = (MAX_AB > GAP) ? MAX_AB : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 2);

    // Instruction field positions
    localparam int unsigned CEN_P    = 32;
    localparam int unsigned WEN_P    = 31;
    localparam int unsigned A_P_LO   = 20;
    localparam int unsigned A_P_HI   = A_P_LO + ADDR_W - 1;
    localparam int unsigned CEN_X    = 19;
    localparam int unsigned A_X_LO   = 7;
    localparam int unsigned A_X_HI   = A_X_LO + ADDR_W - 1;
    localparam int unsigned OFIFO_RD = 6;
    localparam int unsigned L0_RD    = 3;
    localparam int unsigned L0_WR    = 2;
    localparam int unsigned EXECUTE  = 1;
    localparam int unsigned LOAD     = 0;

    localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_W_L0   = 3'd1;
    localparam logic [2:0] S_W_LOAD = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_A_L0   = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_DRAIN  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CNT_W-1:0]  rd_cnt, rd_cnt_n;
    logic [CNT_W-1:0]  wr_cnt, wr_cnt_n;
    logic              pend, pend_n;
    logic [ADDR_W-1:0] w_base_q, w_base_n;
    logic [ADDR_W-1:0] a_base_q, a_base_n;
    logic [ADDR_W-1:0] p_base_q, p_base_n;
    logic [INST_W-1:0] inst_n;
    logic              busy_n, done_n, err_n;
    logic              rd_issue;
`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall, stall_n;
`endif

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            pend     <= 1'b0;
            w_base_q <= '0;
            a_base_q <= '0;
            p_base_q <= '0;
            inst     <= IDLE_WORD;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            stall    <= '0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rd_cnt   <= rd_cnt_n;
            wr_cnt   <= wr_cnt_n;
            pend     <= pend_n;
            w_base_q <= w_base_n;
            a_base_q <= a_base_n;
            p_base_q <= p_base_n;
            inst     <= inst_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
`ifdef SEQ_TIMEOUT_EN
            stall    <= stall_n;
`endif
        end
    end

    // Next state and the instruction word for the current state-cycle
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rd_cnt_n = rd_cnt;
        wr_cnt_n = wr_cnt;
        pend_n   = pend;
        w_base_n = w_base_q;
        a_base_n = a_base_q;
        p_base_n = p_base_q;
        inst_n   = IDLE_WORD;
        busy_n   = (state != S_IDLE);
        done_n   = 1'b0;
        err_n    = err;
        rd_issue = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        stall_n  = stall;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_W_L0;
                    cnt_n    = '0;
                    rd_cnt_n = '0;
                    wr_cnt_n = '0;
                    pend_n   = 1'b0;
                    w_base_n = w_base;
                    a_base_n = a_base;
                    p_base_n = p_base;
                    err_n    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
                    stall_n  = '0;
`endif
                end
            end
            S_W_L0: begin
                // xmem read at c, data written into L0 one cycle later
                if (cnt < CNT_W'(ROW)) begin
                    inst_n[CEN_X]         = 1'b0;
                    inst_n[A_X_HI:A_X_LO] = ADDR_W'(w_base_q + ADDR_W'(cnt));
                end
                if (cnt != '0) inst_n[L0_WR] = 1'b1;
                if (cnt == CNT_W'(ROW)) begin
                    state_n = S_W_LOAD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = CNT_W'(cnt + CNT_W'(1));
                end
            end
            S_W_LOAD: begin
                if (cnt < CNT_W'(ROW)) inst_n[L0_RD] = 1'b1;
                if (cnt != '0) inst_n[LOAD] = 1'b1;
                if (cnt == CNT_W'(ROW)) begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = CNT_W'(cnt + CNT_W'(1));
                end
            end
            S_GAP: begin
                if (cnt == CNT_W'(GAP - 1)) begin
                    state_n = S_A_L0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = CNT_W'(cnt + CNT_W'(1));
                end
            end
            S_A_L0: begin
                if (cnt < CNT_W'(LEN_NIJ)) begin
                    inst_n[CEN_X]         = 1'b0;
                    inst_n[A_X_HI:A_X_LO] = ADDR_W'(a_base_q + ADDR_W'(cnt));
                end
                if (cnt != '0) inst_n[L0_WR] = 1'b1;
                if (cnt == CNT_W'(LEN_NIJ)) begin
                    state_n = S_EXEC;
                    cnt_n   = '0;
                end else begin
                    cnt_n = CNT_W'(cnt + CNT_W'(1));
                end
            end
            S_EXEC: begin
                if (cnt < CNT_W'(LEN_NIJ)) inst_n[L0_RD] = 1'b1;
                if (cnt != '0) inst_n[EXECUTE] = 1'b1;
                if (cnt == CNT_W'(LEN_NIJ)) begin
                    state_n = S_DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = CNT_W'(cnt + CNT_W'(1));
                end
            end
            S_DRAIN: begin
                // A read issued last cycle lands now and is written to pmem
                if (pend) begin
                    inst_n[CEN_P]         = 1'b0;
                    inst_n[WEN_P]         = 1'b0;
                    inst_n[A_P_HI:A_P_LO] = ADDR_W'(p_base_q + ADDR_W'(wr_cnt));
                    wr_cnt_n              = CNT_W'(wr_cnt + CNT_W'(1));
                end
                rd_issue = ofifo_valid && (rd_cnt < CNT_W'(LEN_NIJ));
                if (rd_issue) begin
                    inst_n[OFIFO_RD] = 1'b1;
                    rd_cnt_n         = CNT_W'(rd_cnt + CNT_W'(1));
                end
                pend_n = rd_issue;
                if (pend && (wr_cnt == CNT_W'(LEN_NIJ - 1))) state_n = S_DONE;
`ifdef SEQ_TIMEOUT_EN
                // Watchdog: consecutive cycles with a read owed but no data available
                if (rd_issue) begin
                    stall_n = '0;
                end else if (rd_cnt < CNT_W'(LEN_NIJ)) begin
                    stall_n = STALL_W'(stall + STALL_W'(1));
                    if (stall == STALL_W'(TIMEOUT - 1)) begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end
                end
`endif
            end
            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
